// File: rtl/sar_adc.sv
// sar_adc: successive-approximation ADC with an internal R-string DAC feedback model
module sar_adc #(
    parameter int n = 3
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         start,
    input  real          VIN,
    input  real          VSUP,
    output logic [n-1:0] Q,
    output logic         busy,
    output logic         done,
    output real          VDAC
);
    localparam real nlevels = real'(2 ** n);
    typedef enum logic [1:0] {IDLE, CONVERT, DONE} state_t;
    state_t       state;
    logic [n-1:0] sar;
    logic [n-1:0] trial;
    logic [n-1:0] next_sar;
    logic [3:0]   bit_idx;
    real          vin_h;
    real          vref_h;
    // candidate code: bits already kept plus the bit under test
    always_comb trial = sar | (n'(1) << bit_idx);
    // keep the bit when the held input reaches the trial level (boundary resolves upward)
    always_comb next_sar = (vin_h >= vref_h * real'(trial) / nlevels) ? trial : sar;
    // DAC shows the trial level while converting, otherwise the last result
    always_comb VDAC = (state == CONVERT) ? vref_h * real'(trial) / nlevels
                                          : vref_h * real'(Q) / nlevels;
    // control FSM: capture on start, resolve one bit per cycle MSB-first, pulse done
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state   <= IDLE;
            Q       <= '0;
            sar     <= '0;
            bit_idx <= 4'(n - 1);
            busy    <= 1'b0;
            done    <= 1'b0;
            vin_h   <= 0.0;
            vref_h  <= 0.0;
        end else begin
            case (state)
                IDLE, DONE: begin
                    done <= 1'b0;
                    if (start) begin
                        vin_h   <= VIN;
                        vref_h  <= VSUP;
                        sar     <= '0;
                        bit_idx <= 4'(n - 1);
                        busy    <= 1'b1;
                        state   <= CONVERT;
                    end else begin
                        busy  <= 1'b0;
                        state <= IDLE;
                    end
                end
                CONVERT: begin
                    sar <= next_sar;
                    if (bit_idx == 4'd0) begin
                        Q     <= next_sar;
                        done  <= 1'b1;
                        busy  <= 1'b0;
                        state <= DONE;
                    end else begin
                        bit_idx <= bit_idx - 4'd1;
                    end
                end
                default: begin
                    busy  <= 1'b0;
                    done  <= 1'b0;
                    state <= IDLE;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_sar_adc.sv
// tb_sar_adc: directed-vector bench for sar_adc (n=3)
module tb_sar_adc;
    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       start = 1'b0;
    real        vin = 0.0;
    real        vsup = 1.0;
    logic [2:0] q;
    logic       busy;
    logic       done;
    real        vdac;
    int         n_checks = 0;
    int         n_fail = 0;
    int         dones;

    sar_adc #(.n(3)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .VIN(vin), .VSUP(vsup),
        .Q(q), .busy(busy), .done(done), .VDAC(vdac)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input real got, input real exp);
        n_checks++;
        if ((got - exp) > 1.0e-9 || (exp - got) > 1.0e-9) begin
            n_fail++;
            $display("FAIL %s: got %f expected %f", tag, got, exp);
        end
    endtask

    // start pulse, input optionally stepped one cycle later, full cycle-by-cycle check
    task automatic do_conv(input string tag, input real v0, input real v1, input int expq);
        vin = v0;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        for (int i = 0; i < 3; i++) begin
            check({tag, "_busy"}, real'(busy), 1.0);
            check({tag, "_nodone"}, real'(done), 0.0);
            @(negedge clk);
            vin = v1;
        end
        check({tag, "_done"}, real'(done), 1.0);
        check({tag, "_busy_lo"}, real'(busy), 0.0);
        check({tag, "_q"}, real'(q), real'(expq));
        check({tag, "_vdac"}, vdac, vsup * real'(expq) / 8.0);
        @(negedge clk);
        check({tag, "_done_drop"}, real'(done), 0.0);
        check({tag, "_q_hold"}, real'(q), real'(expq));
    endtask

    initial begin
        repeat (2) @(negedge clk);
        check("rst_q", real'(q), 0.0);
        check("rst_busy", real'(busy), 0.0);
        check("rst_done", real'(done), 0.0);
        check("rst_vdac", vdac, 0.0);
        rst_n = 1'b1;
        @(negedge clk);
        vin = 0.55;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        check("t1_vdac_msb_trial", vdac, 0.5);
        repeat (3) @(negedge clk);
        check("t1_done", real'(done), 1.0);
        check("t1_q", real'(q), 4.0);
        check("t1_vdac", vdac, 0.5);
        @(negedge clk);
        do_conv("t1", 0.55, 0.55, 4);
        do_conv("exact", 0.625, 0.625, 5);
        do_conv("over", 1.2, 1.2, 7);
        do_conv("neg", -0.3, -0.3, 0);
        do_conv("near_top", 0.999, 0.999, 7);
        do_conv("step", 0.2, 0.9, 1);
        vsup = 2.0;
        do_conv("vsup2", 1.1, 1.1, 4);
        vsup = 1.0;
        // continuous start: a done every fourth cycle
        vin = 0.3;
        start = 1'b1;
        dones = 0;
        for (int i = 1; i <= 12; i++) begin
            @(negedge clk);
            check("cont_done", real'(done), (i % 4 == 0) ? 1.0 : 0.0);
            check("cont_busy", real'(busy), (i % 4 == 0) ? 0.0 : 1.0);
            if (done) begin
                dones++;
                check("cont_q", real'(q), 2.0);
            end
        end
        check("cont_count", real'(dones), 3.0);
        start = 1'b0;
        @(negedge clk);
        check("cont_idle", real'(busy), 0.0);
        // extra start pulse while busy yields a single done
        vin = 0.3;
        start = 1'b1;
        dones = 0;
        for (int i = 1; i <= 8; i++) begin
            @(negedge clk);
            start = (i == 2);
            if (done) dones++;
        end
        check("busy_start_count", real'(dones), 1.0);
        // reset at the second conversion edge aborts without done
        vin = 0.8;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        check("abort_busy", real'(busy), 0.0);
        check("abort_q", real'(q), 0.0);
        check("abort_vdac", vdac, 0.0);
        dones = 0;
        for (int i = 0; i < 5; i++) begin
            if (done) dones++;
            @(negedge clk);
        end
        check("abort_nodone", real'(dones), 0.0);
        do_conv("after_abort", 0.8, 0.8, 6);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    // busy and done are never high together
    always @(negedge clk) begin
        if (rst_n && busy && done) begin
            n_checks++;
            n_fail++;
            $display("FAIL busy_and_done: got busy=1 done=1 expected not both");
        end
    end
endmodule
